// File: rtl/rc4_encrypt_core.sv
// RC4 encryptor: S-box init, key schedule and PRGA over an external
// single-port S-box RAM, reading plaintext and writing ciphertext RAMs.
module rc4_encrypt_core #(
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [23:0]       secret_key,
   output logic [7:0]        s_addr,
   output logic [7:0]        s_wdata,
   output logic              s_wren,
   input  logic [7:0]        s_q,
   output logic [ADDR_W-1:0] pt_addr,
   input  logic [7:0]        pt_q,
   output logic [ADDR_W-1:0] ct_addr,
   output logic [7:0]        ct_data,
   output logic              ct_wren,
   output logic              busy,
   output logic              done,
   output logic              pt_invalid
);

   localparam logic [7:0] K_LAST = 8'(MSG_LEN - 1);

   typedef enum logic [4:0] {
      IDLE,
      INIT,
      K_RI,
      K_RIW,
      K_RJ,
      K_RJW,
      K_WI,
      K_WJ,
      P_RI,
      P_RIW,
      P_RJ,
      P_RJW,
      P_WI,
      P_WJ,
      P_RF,
      P_RFW,
      P_CT,
      DONE
   } state_t;

   state_t state, state_n;

   logic [7:0]  i, i_n;
   logic [7:0]  j, j_n;
   logic [7:0]  k, k_n;
   logic [1:0]  kidx, kidx_n;
   logic [23:0] key, key_n;
   logic [7:0]  si, si_n;
   logic [7:0]  sj, sj_n;
   logic [7:0]  ptb, ptb_n;

   logic [7:0]        s_addr_n;
   logic [7:0]        s_wdata_n;
   logic              s_wren_n;
   logic [ADDR_W-1:0] pt_addr_n;
   logic [ADDR_W-1:0] ct_addr_n;
   logic [7:0]        ct_data_n;
   logic              ct_wren_n;
   logic              busy_n;
   logic              done_n;
   logic              pt_invalid_n;

   logic [7:0] kbyte;
   logic [7:0] j_ksa;
   logic [7:0] j_prga;
   logic       pt_ok;

   // Key byte for the current key-schedule step, byte0 is the MSB.
   always_comb begin
      kbyte = key[7:0];
      unique case (kidx)
         2'd0:    kbyte = key[23:16];
         2'd1:    kbyte = key[15:8];
         default: kbyte = key[7:0];
      endcase
   end

   assign j_ksa  = j + s_q + kbyte;
   assign j_prga = j + s_q;
   assign pt_ok  = (pt_q == 8'h20) ||
                   ((pt_q >= 8'h61) && (pt_q <= 8'h7A));

   // State, datapath and registered RAM strobes; reset clears everything.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         i          <= '0;
         j          <= '0;
         k          <= '0;
         kidx       <= '0;
         key        <= '0;
         si         <= '0;
         sj         <= '0;
         ptb        <= '0;
         s_addr     <= '0;
         s_wdata    <= '0;
         s_wren     <= 1'b0;
         pt_addr    <= '0;
         ct_addr    <= '0;
         ct_data    <= '0;
         ct_wren    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pt_invalid <= 1'b0;
      end else begin
         state      <= state_n;
         i          <= i_n;
         j          <= j_n;
         k          <= k_n;
         kidx       <= kidx_n;
         key        <= key_n;
         si         <= si_n;
         sj         <= sj_n;
         ptb        <= ptb_n;
         s_addr     <= s_addr_n;
         s_wdata    <= s_wdata_n;
         s_wren     <= s_wren_n;
         pt_addr    <= pt_addr_n;
         ct_addr    <= ct_addr_n;
         ct_data    <= ct_data_n;
         ct_wren    <= ct_wren_n;
         busy       <= busy_n;
         done       <= done_n;
         pt_invalid <= pt_invalid_n;
      end
   end

   // Next-state and next-output logic; each read is address, wait, consume.
   always_comb begin
      state_n      = state;
      i_n          = i;
      j_n          = j;
      k_n          = k;
      kidx_n       = kidx;
      key_n        = key;
      si_n         = si;
      sj_n         = sj;
      ptb_n        = ptb;
      s_addr_n     = s_addr;
      s_wdata_n    = s_wdata;
      s_wren_n     = 1'b0;
      pt_addr_n    = pt_addr;
      ct_addr_n    = ct_addr;
      ct_data_n    = ct_data;
      ct_wren_n    = 1'b0;
      busy_n       = busy;
      done_n       = 1'b0;
      pt_invalid_n = pt_invalid;

      unique case (state)
         IDLE: begin
            if (start) begin
               key_n        = secret_key;
               i_n          = '0;
               j_n          = '0;
               k_n          = '0;
               kidx_n       = '0;
               pt_invalid_n = 1'b0;
               busy_n       = 1'b1;
               state_n      = INIT;
            end
         end
         INIT: begin
            s_addr_n  = i;
            s_wdata_n = i;
            s_wren_n  = 1'b1;
            i_n       = i + 8'd1;
            if (i == 8'hFF) begin
               j_n     = '0;
               kidx_n  = '0;
               state_n = K_RI;
            end
         end
         K_RI: begin
            s_addr_n = i;
            state_n  = K_RIW;
         end
         K_RIW: state_n = K_RJ;
         K_RJ: begin
            si_n     = s_q;
            j_n      = j_ksa;
            s_addr_n = j_ksa;
            state_n  = K_RJW;
         end
         K_RJW: state_n = K_WI;
         K_WI: begin
            sj_n      = s_q;
            s_addr_n  = i;
            s_wdata_n = s_q;
            s_wren_n  = 1'b1;
            state_n   = K_WJ;
         end
         K_WJ: begin
            s_addr_n  = j;
            s_wdata_n = si;
            s_wren_n  = 1'b1;
            i_n       = i + 8'd1;
            kidx_n    = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
            if (i == 8'hFF) begin
               i_n     = '0;
               j_n     = '0;
               k_n     = '0;
               state_n = P_RI;
            end else begin
               state_n = K_RI;
            end
         end
         P_RI: begin
            i_n       = i + 8'd1;
            s_addr_n  = i + 8'd1;
            pt_addr_n = ADDR_W'(k);
            state_n   = P_RIW;
         end
         P_RIW: state_n = P_RJ;
         P_RJ: begin
            si_n     = s_q;
            j_n      = j_prga;
            s_addr_n = j_prga;
            ptb_n    = pt_q;
            if (!pt_ok) pt_invalid_n = 1'b1;
            state_n  = P_RJW;
         end
         P_RJW: state_n = P_WI;
         P_WI: begin
            sj_n      = s_q;
            s_addr_n  = i;
            s_wdata_n = s_q;
            s_wren_n  = 1'b1;
            state_n   = P_WJ;
         end
         P_WJ: begin
            s_addr_n  = j;
            s_wdata_n = si;
            s_wren_n  = 1'b1;
            state_n   = P_RF;
         end
         P_RF: begin
            s_addr_n = si + sj;
            state_n  = P_RFW;
         end
         P_RFW: state_n = P_CT;
         P_CT: begin
            ct_addr_n = ADDR_W'(k);
            ct_data_n = s_q ^ ptb;
            ct_wren_n = 1'b1;
            if (k == K_LAST) begin
               done_n  = 1'b1;
               busy_n  = 1'b0;
               state_n = DONE;
            end else begin
               k_n     = k + 8'd1;
               state_n = P_RI;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Scoreboard bench for rc4_encrypt_core: RAM models, a plain RC4
// reference model, randomized keys/messages and a ct-write monitor.
module tb_rc4_encrypt_core;

   localparam int MSG_LEN = 32;
   localparam int ADDR_W  = 5;

   logic              clk;
   logic              reset;
   logic              start;
   logic [23:0]       secret_key;
   logic [7:0]        s_addr;
   logic [7:0]        s_wdata;
   logic              s_wren;
   logic [7:0]        s_q;
   logic [ADDR_W-1:0] pt_addr;
   logic [7:0]        pt_q;
   logic [ADDR_W-1:0] ct_addr;
   logic [7:0]        ct_data;
   logic              ct_wren;
   logic              busy;
   logic              done;
   logic              pt_invalid;

   rc4_encrypt_core #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .secret_key (secret_key),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_wren     (s_wren),
      .s_q        (s_q),
      .pt_addr    (pt_addr),
      .pt_q       (pt_q),
      .ct_addr    (ct_addr),
      .ct_data    (ct_data),
      .ct_wren    (ct_wren),
      .busy       (busy),
      .done       (done),
      .pt_invalid (pt_invalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] smem  [256];
   logic [7:0] ptmem [MSG_LEN];
   logic [7:0] ctmem [MSG_LEN];

   always @(posedge clk) begin
      if (s_wren) smem[s_addr] <= s_wdata;
      s_q <= smem[s_addr];
   end

   always @(posedge clk) pt_q <= ptmem[pt_addr];

   always @(posedge clk) if (ct_wren) ctmem[ct_addr] <= ct_data;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void chk(string name, longint got, longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [7:0]        data;
   } exp_t;

   exp_t sb[$];

   function automatic bit txt_ok(logic [7:0] b);
      return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
   endfunction

   // Plain RC4 keystream computed with integer arrays.
   function automatic void rc4_ks(input logic [23:0] key,
                                  output logic [7:0] ks [MSG_LEN]);
      int s [256];
      int i, j, t, kb;
      for (int n = 0; n < 256; n++) s[n] = n;
      j = 0;
      for (int n = 0; n < 256; n++) begin
         kb = int'(key[(2 - n % 3) * 8 +: 8]);
         j = (j + s[n] + kb) % 256;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 0;
      j = 0;
      for (int n = 0; n < MSG_LEN; n++) begin
         i = (i + 1) % 256;
         j = (j + s[i]) % 256;
         t = s[i]; s[i] = s[j]; s[j] = t;
         ks[n] = 8'(s[(s[i] + s[j]) % 256]);
      end
   endfunction

   function automatic logic [63:0] outs();
      return 64'({s_addr, s_wdata, s_wren, pt_addr, ct_addr,
                  ct_data, ct_wren, busy, done, pt_invalid});
   endfunction

   // Monitor: every ciphertext write is popped off the scoreboard.
   exp_t e;
   always @(negedge clk) begin
      if (!reset) begin
         if (ct_wren) begin
            n_checks++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL ct_unexpected: got write %0h@%0h required none",
                        ct_data, ct_addr);
            end else begin
               e = sb.pop_front();
               chk("ct_addr", ct_addr, e.addr);
               chk("ct_data", ct_data, e.data);
            end
         end
         if (done) chk("done_all_written", sb.size(), 0);
      end
   end

   task automatic fill_text();
      for (int n = 0; n < MSG_LEN; n++)
         ptmem[n] = ($urandom_range(5) == 0) ? 8'h20
                    : 8'(8'h61 + $urandom_range(25));
   endtask

   task automatic push_exp(input logic [23:0] key, output bit inv);
      logic [7:0] ks [MSG_LEN];
      exp_t x;
      rc4_ks(key, ks);
      inv = 1'b0;
      for (int n = 0; n < MSG_LEN; n++) begin
         x.addr = ADDR_W'(n);
         x.data = ks[n] ^ ptmem[n];
         sb.push_back(x);
         if (!txt_ok(ptmem[n])) inv = 1'b1;
      end
   endtask

   task automatic pulse_start(input logic [23:0] key);
      secret_key = key;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run(input logic [23:0] key, input bit poke,
                      input bit probe);
      bit inv;
      bit got_done;
      int cyc;
      int ierr;
      push_exp(key, inv);
      pulse_start(key);
      chk("busy_after_start", busy, 1);
      chk("pt_invalid_cleared", pt_invalid, 0);
      cyc = 1;
      ierr = 0;
      got_done = 1'b0;
      while (!got_done && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc == 10 || cyc == 300 || cyc == 900);
         if (start) secret_key = 24'($urandom);
         if (probe && cyc >= 2 && cyc <= 257)
            if (s_wren !== 1'b1 || s_addr !== 8'(cyc - 2)) ierr++;
         if (probe && cyc == 258) begin
            chk("init_wren_end", s_wren, 0);
            for (int n = 0; n < 256; n++)
               if (smem[n] !== 8'(n)) ierr++;
            chk("init_probe", ierr, 0);
         end
         got_done = done;
      end
      chk("done_seen", got_done, 1);
      chk("busy_low_at_done", busy, 0);
      start = poke;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("pt_invalid", pt_invalid, inv);
      @(negedge clk);
      chk("idle_after_done", busy, 0);
      chk("queue_drained", sb.size(), 0);
   endtask

   logic [7:0] kat [9];
   string      msg;

   task automatic check_kat();
      for (int n = 0; n < 9; n++) chk("kat_ct", ctmem[n], kat[n]);
   endtask

   task automatic roundtrip();
      logic [7:0] ks [MSG_LEN];
      logic [23:0] found;
      bit ok;
      found = 24'hFFFFFF;
      for (int c = 24'h000100; c <= 24'h0001FF; c++) begin
         rc4_ks(24'(c), ks);
         ok = 1'b1;
         for (int n = 0; n < MSG_LEN; n++)
            if (!txt_ok(ks[n] ^ ctmem[n])) ok = 1'b0;
         if (ok && found == 24'hFFFFFF) found = 24'(c);
      end
      chk("roundtrip_key", found, 24'h000123);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      kat = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9,
              8'h40, 8'hAF, 8'h0A, 8'hD3};
      msg = "Plaintext";
      reset = 1'b1;
      start = 1'b0;
      secret_key = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outs(), 0);
      reset = 1'b0;

      fill_text();
      for (int n = 0; n < 9; n++) ptmem[n] = msg[n];
      run(24'h4B6579, 1'b0, 1'b1);
      check_kat();

      run(24'h4B6579, 1'b1, 1'b0);
      check_kat();

      fill_text();
      ptmem[3] = 8'h41;
      run(24'($urandom), 1'b0, 1'b0);
      chk("pt_invalid_sticky", pt_invalid, 1);

      for (int r = 0; r < 2; r++) begin
         fill_text();
         run(24'($urandom), 1'b0, 1'b0);
      end

      for (int n = 0; n < MSG_LEN; n++) ptmem[n] = 8'($urandom);
      run(24'($urandom), 1'b0, 1'b0);

      begin
         bit inv;
         fill_text();
         push_exp(24'h9A3C01, inv);
         pulse_start(24'h9A3C01);
         repeat (1900) @(negedge clk);
         chk("busy_before_reset", busy, 1);
         @(posedge clk);
         #2 reset = 1'b1;
         #1 chk("outs_async_reset", outs(), 0);
         sb.delete();
         @(negedge clk);
         @(negedge clk);
         reset = 1'b0;
         run(24'h9A3C01, 1'b0, 1'b0);
      end

      fill_text();
      run(24'h000123, 1'b0, 1'b0);
      roundtrip();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
